// File: rtl/sha512_msg_padder_pkg.sv
// Shared types and constants for the SHA-512 message padder.
package sha512_msg_padder_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    FILL  = ST_FILL,
    PAD   = ST_PAD,
    ISSUE = ST_ISSUE,
    HOLD  = ST_HOLD
  } e_pad_state;

  localparam logic [63:0] PAD_BYTE    = 64'h8000_0000_0000_0000;
  localparam logic [3:0]  LEN_HI_WORD = 4'd14;
  localparam logic [3:0]  LEN_LO_WORD = 4'd15;

endpackage

// File: rtl/sha512_pad_word.sv
// Masks the final message word to its valid bytes and inserts the 0x80 terminator byte.
module sha512_pad_word
  import sha512_msg_padder_pkg::*;
(
  input  logic [63:0] in_data,
  input  logic [3:0]  nb,
  output logic [63:0] word,
  output logic        placed,
  output logic [3:0]  nb_eff
);

  // Byte k (k=0 in the top byte) is kept below nb, becomes 0x80 at nb, zero above.
  always_comb begin
    nb_eff = (nb > 4'd8) ? 4'd8 : nb;
    word   = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nb_eff) begin
        word[63-8*k -: 8] = in_data[63-8*k -: 8];
      end else if (4'(k) == nb_eff) begin
        word[63-8*k -: 8] = PAD_BYTE[63:56];
      end else begin
        word[63-8*k -: 8] = 8'h00;
      end
    end
    placed = (nb_eff < 4'd8);
  end

endmodule

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: packs 64-bit words into 1024-bit blocks, appends the
// 0x80/zero/length padding and hands each block to the core with init/next pulses.
module sha512_msg_padder
  import sha512_msg_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          zeroize,
  input  logic [31:0]   mode_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  input  logic          core_ready,
  output logic [1023:0] core_block,
  output logic [31:0]   core_mode,
  output logic          core_init,
  output logic          core_next,
  output logic          msg_issued
);

  logic [1:0]       state_r;
  logic [3:0]       widx_r;
  logic [LEN_W-1:0] bitlen_r;
  logic             first_r;
  logic             placed80_r;
  logic             final_r;
  logic             pad_after_r;
  logic [63:0]      buf_r [16];
  logic [31:0]      mode_r;
  logic             init_r;
  logic             next_r;
  logic             issued_r;

  logic [63:0]      pad_word_s;
  logic             pad_placed_s;
  logic [3:0]       nb_eff_s;
  logic             accept_s;
  logic [127:0]     len128_s;

  sha512_pad_word u_pad_word (
    .in_data (in_data),
    .nb      (in_bytes),
    .word    (pad_word_s),
    .placed  (pad_placed_s),
    .nb_eff  (nb_eff_s)
  );

  assign accept_s = in_valid && (state_r == ST_FILL);
  assign len128_s = 128'(bitlen_r);

  // Block FSM: fill from input, pad, then wait for the core and pulse init/next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_FILL;
      widx_r      <= 4'd0;
      bitlen_r    <= '0;
      first_r     <= 1'b1;
      placed80_r  <= 1'b0;
      final_r     <= 1'b0;
      pad_after_r <= 1'b0;
      mode_r      <= 32'd0;
      init_r      <= 1'b0;
      next_r      <= 1'b0;
      issued_r    <= 1'b0;
      for (int i = 0; i < 16; i++) buf_r[i] <= 64'd0;
    end else if (zeroize) begin
      state_r     <= ST_FILL;
      widx_r      <= 4'd0;
      bitlen_r    <= '0;
      first_r     <= 1'b1;
      placed80_r  <= 1'b0;
      final_r     <= 1'b0;
      pad_after_r <= 1'b0;
      mode_r      <= 32'd0;
      init_r      <= 1'b0;
      next_r      <= 1'b0;
      issued_r    <= 1'b0;
      for (int i = 0; i < 16; i++) buf_r[i] <= 64'd0;
    end else begin
      init_r   <= 1'b0;
      next_r   <= 1'b0;
      issued_r <= 1'b0;
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (first_r && (widx_r == 4'd0)) mode_r <= mode_in;
            if (in_last) begin
              buf_r[widx_r] <= pad_word_s;
              placed80_r    <= pad_placed_s;
              bitlen_r      <= bitlen_r + LEN_W'({nb_eff_s, 3'b000});
              if (widx_r == 4'd15) begin
                state_r     <= ST_ISSUE;
                final_r     <= 1'b0;
                pad_after_r <= 1'b1;
              end else begin
                widx_r  <= widx_r + 4'd1;
                state_r <= ST_PAD;
              end
            end else begin
              buf_r[widx_r] <= in_data;
              bitlen_r      <= bitlen_r + LEN_W'(64'd64);
              if (widx_r == 4'd15) begin
                state_r     <= ST_ISSUE;
                final_r     <= 1'b0;
                pad_after_r <= 1'b0;
              end else begin
                widx_r <= widx_r + 4'd1;
              end
            end
          end
        end
        ST_PAD: begin
          // The length needs both trailing words, so it can only close a block that already holds 0x80.
          if ((widx_r == LEN_HI_WORD) && placed80_r) begin
            buf_r[LEN_HI_WORD] <= len128_s[127:64];
            buf_r[LEN_LO_WORD] <= len128_s[63:0];
            state_r            <= ST_ISSUE;
            final_r            <= 1'b1;
          end else begin
            buf_r[widx_r] <= placed80_r ? 64'd0 : PAD_BYTE;
            placed80_r    <= 1'b1;
            if (widx_r == 4'd15) begin
              state_r     <= ST_ISSUE;
              final_r     <= 1'b0;
              pad_after_r <= 1'b1;
            end else begin
              widx_r <= widx_r + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            init_r   <= first_r;
            next_r   <= !first_r;
            issued_r <= final_r;
            first_r  <= 1'b0;
            widx_r   <= 4'd0;
            state_r  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Core ready is ignored here: it still reads high on the cycle of the pulse.
          if (final_r) begin
            bitlen_r   <= '0;
            first_r    <= 1'b1;
            placed80_r <= 1'b0;
            final_r    <= 1'b0;
            state_r    <= ST_FILL;
          end else begin
            state_r <= pad_after_r ? ST_PAD : ST_FILL;
          end
        end
        default: state_r <= ST_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign core_block[1023-64*g -: 64] = buf_r[g];
  end

  assign in_ready   = (state_r == ST_FILL);
  assign core_mode  = mode_r;
  assign core_init  = init_r;
  assign core_next  = next_r;
  assign msg_issued = issued_r;

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Directed self-checking bench for sha512_msg_padder.
module tb_sha512_msg_padder;

  logic          clk;
  logic          reset_n;
  logic          zeroize;
  logic [31:0]   mode_in;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          core_ready;
  logic [1023:0] core_block;
  logic [31:0]   core_mode;
  logic          core_init;
  logic          core_next;
  logic          msg_issued;

  int checks = 0;
  int errors = 0;

  logic [1023:0] cap_blk;
  logic [31:0]   cap_mode;
  logic          cap_init;
  logic          cap_next;
  logic          cap_issued;
  logic [63:0]   exp_w [16];
  logic [1023:0] snap_blk;
  int            pulses;

  sha512_msg_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .mode_in    (mode_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .core_ready (core_ready),
    .core_block (core_block),
    .core_mode  (core_mode),
    .core_init  (core_init),
    .core_next  (core_next),
    .msg_issued (msg_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [1023:0] blk, input int i);
    return blk[1023-64*i -: 64];
  endfunction

  function automatic logic [63:0] d_word(input int i);
    return {8'(i + 1), 56'h11_2233_4455_6677};
  endfunction

  task automatic clr_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 64'd0;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    in_last  = 1'b0;
    in_bytes = 4'd0;
  endtask

  task automatic wait_pulse(input string tag);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (core_init || core_next) seen = 1'b1;
      n++;
    end
    check({tag, "_pulse_seen"}, 64'(seen), 64'd1);
    cap_blk    = core_block;
    cap_mode   = core_mode;
    cap_init   = core_init;
    cap_next   = core_next;
    cap_issued = msg_issued;
    @(negedge clk);
    check({tag, "_pulse_single"}, 64'(core_init | core_next | msg_issued), 64'd0);
  endtask

  task automatic expect_block(input string tag, input logic exp_init, input logic exp_issued);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_w%0d", tag, i), word_of(cap_blk, i), exp_w[i]);
    check({tag, "_init"}, 64'(cap_init), 64'(exp_init));
    check({tag, "_next"}, 64'(cap_next), 64'(!exp_init));
    check({tag, "_issued"}, 64'(cap_issued), 64'(exp_issued));
  endtask

  initial begin
    reset_n    = 1'b0;
    zeroize    = 1'b0;
    mode_in    = 32'd0;
    in_valid   = 1'b0;
    in_data    = 64'd0;
    in_last    = 1'b0;
    in_bytes   = 4'd0;
    core_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_block_zero", 64'(|core_block), 64'd0);
    check("rst_mode", 64'(core_mode), 64'd0);
    check("rst_pulses", 64'({core_init, core_next, msg_issued}), 64'd0);
    reset_n = 1'b1;

    // "abc": single block, length 24 bits
    mode_in = 32'd3;
    send(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    mode_in = 32'hDEAD_0000;
    wait_pulse("abc");
    clr_exp();
    exp_w[0]  = 64'h6162_6380_0000_0000;
    exp_w[15] = 64'h18;
    expect_block("abc", 1'b1, 1'b1);
    check("abc_mode", 64'(cap_mode), 64'd3);

    // Empty message: stale input bytes must be masked away
    mode_in = 32'd5;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    wait_pulse("empty");
    clr_exp();
    exp_w[0] = 64'h8000_0000_0000_0000;
    expect_block("empty", 1'b1, 1'b1);
    check("empty_mode", 64'(cap_mode), 64'd5);

    // 109 bytes: partial last word still fits with the length
    for (int i = 0; i < 13; i++) send(d_word(i), 1'b0, 4'd8);
    send(64'h1122_3344_5566_7788, 1'b1, 4'd5);
    wait_pulse("b109");
    clr_exp();
    for (int i = 0; i < 13; i++) exp_w[i] = d_word(i);
    exp_w[13] = 64'h1122_3344_5580_0000;
    exp_w[15] = 64'h368;
    expect_block("b109", 1'b1, 1'b1);

    // 112 bytes: 0x80 lands in word 14, length needs an extra block
    for (int i = 0; i < 14; i++) send(d_word(i), (i == 13), 4'd8);
    wait_pulse("b112_1");
    clr_exp();
    for (int i = 0; i < 14; i++) exp_w[i] = d_word(i);
    exp_w[14] = 64'h8000_0000_0000_0000;
    expect_block("b112_1", 1'b1, 1'b0);
    wait_pulse("b112_2");
    clr_exp();
    exp_w[15] = 64'h380;
    expect_block("b112_2", 1'b0, 1'b1);

    // 128 bytes: full data block, then padding block
    for (int i = 0; i < 16; i++) send(d_word(i), (i == 15), 4'd8);
    wait_pulse("b128_1");
    clr_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = d_word(i);
    expect_block("b128_1", 1'b1, 1'b0);
    wait_pulse("b128_2");
    clr_exp();
    exp_w[0]  = 64'h8000_0000_0000_0000;
    exp_w[15] = 64'h400;
    expect_block("b128_2", 1'b0, 1'b1);

    // Core busy while the block waits in ISSUE
    core_ready = 1'b0;
    mode_in    = 32'd7;
    send(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    repeat (20) @(negedge clk);
    snap_blk = core_block;
    pulses   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (core_init || core_next || msg_issued) pulses++;
      if (core_block !== snap_blk) pulses += 100;
    end
    check("stall_no_pulse_stable", 64'(pulses), 64'd0);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_w0", word_of(snap_blk, 0), 64'h6162_6380_0000_0000);
    check("stall_w15", word_of(snap_blk, 15), 64'h18);
    core_ready = 1'b1;
    @(negedge clk);
    check("stall_init", 64'(core_init), 64'd1);
    check("stall_issued", 64'(msg_issued), 64'd1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (core_init || core_next || msg_issued) pulses++;
    end
    check("stall_single_pulse", 64'(pulses), 64'd0);

    // Zeroize mid-message, then a fresh message must start with init
    mode_in = 32'd8;
    for (int i = 0; i < 5; i++) send(d_word(i), 1'b0, 4'd8);
    @(negedge clk);
    check("zz_pre_w0", word_of(core_block, 0), d_word(0));
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check("zz_in_ready", 64'(in_ready), 64'd1);
    check("zz_block_zero", 64'(|core_block), 64'd0);
    check("zz_mode", 64'(core_mode), 64'd0);
    mode_in = 32'd9;
    send(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    wait_pulse("zz_abc");
    clr_exp();
    exp_w[0]  = 64'h6162_6380_0000_0000;
    exp_w[15] = 64'h18;
    expect_block("zz_abc", 1'b1, 1'b1);
    check("zz_abc_mode", 64'(cap_mode), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
